// File: rtl/exe_stage_mc.sv
// exe_stage_mc: multi-cycle ARM execute stage (ALU, NZCV, branch target) with a registered EX/MEM output.
// Define EXE_MUL_EN to build the iterative multiplier for cmd 1010; otherwise that code is unknown.
module exe_stage_mc #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MUL_BPC   = 4,
  parameter int unsigned REG_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           cmd,
  input  logic                 wb_en_in,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic                 s_in,
  input  logic                 b_in,
  input  logic [REG_IDX_W-1:0] dest_in,
  input  logic [ADDR_W-1:0]    pc_in,
  input  logic [DATA_W-1:0]    val_rn,
  input  logic [DATA_W-1:0]    val2,
  input  logic [DATA_W-1:0]    val_rm,
  input  logic [23:0]          imm24,
  input  logic [3:0]           sr_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    alu_res,
  output logic [3:0]           sr_out,
  output logic                 sr_we,
  output logic                 branch_taken,
  output logic [ADDR_W-1:0]    branch_address,
  output logic                 wb_en_out,
  output logic                 mem_read_out,
  output logic                 mem_write_out,
  output logic [REG_IDX_W-1:0] dest_out,
  output logic [DATA_W-1:0]    val_rm_out,
  output logic [ADDR_W-1:0]    pc_out,
  output logic                 busy
);

  localparam int unsigned SUM_W = DATA_W + 1;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  if ((DATA_W % MUL_BPC) != 0) begin : g_bpc_check
    $error("MUL_BPC must divide DATA_W");
  end

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;
  state_t state, state_nxt;

  logic can_load_c, accept_c, is_mul_c, mul_last_c;
  logic load_single_c;

  assign can_load_c    = !out_valid || out_ready;
  assign in_ready      = rst && (state == IDLE) && !flush && can_load_c;
  assign accept_c      = in_valid && in_ready;
  assign load_single_c = accept_c && !is_mul_c;

  // Single-cycle ALU; subtraction is rn + ~val2 + cin so carry out is the no-borrow flag
  logic [DATA_W-1:0] res_c, opb_c;
  logic [SUM_W-1:0]  sum_c;
  logic              cin_c, arith_c, known_c, c_c, v_c;
  logic [3:0]        sr_c;

  always_comb begin
    res_c   = '0;
    opb_c   = val2;
    cin_c   = 1'b0;
    arith_c = 1'b0;
    known_c = 1'b1;
    case (cmd)
      CMD_MOV: res_c = val2;
      CMD_MVN: res_c = ~val2;
      CMD_ADD: arith_c = 1'b1;
      CMD_ADC: begin arith_c = 1'b1; cin_c = sr_in[1]; end
      CMD_SUB: begin arith_c = 1'b1; opb_c = ~val2; cin_c = 1'b1; end
      CMD_SBC: begin arith_c = 1'b1; opb_c = ~val2; cin_c = sr_in[1]; end
      CMD_AND: res_c = val_rn & val2;
      CMD_ORR: res_c = val_rn | val2;
      CMD_EOR: res_c = val_rn ^ val2;
      default: known_c = 1'b0;
    endcase
    sum_c = {1'b0, val_rn} + {1'b0, opb_c} + SUM_W'(cin_c);
    if (arith_c) res_c = sum_c[DATA_W-1:0];
    c_c = arith_c ? sum_c[DATA_W] : sr_in[1];
    v_c = arith_c ? ((val_rn[DATA_W-1] == opb_c[DATA_W-1]) && (res_c[DATA_W-1] != val_rn[DATA_W-1]))
                  : sr_in[0];
    sr_c = known_c ? {res_c[DATA_W-1], (res_c == '0), c_c, v_c} : sr_in;
  end

  logic signed [25:0] off_c;
  logic [ADDR_W-1:0]  br_addr_c;
  assign off_c     = {imm24, 2'b00};
  assign br_addr_c = pc_in + ADDR_W'(off_c);

`ifdef EXE_MUL_EN
  localparam logic [3:0]  CMD_MUL   = 4'b1010;
  localparam int unsigned MUL_STEPS = DATA_W / MUL_BPC;
  localparam int unsigned CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  logic [DATA_W-1:0]    mcand, mplier, acc, pp_c, cap_rm;
  logic [CNT_W-1:0]     count;
  logic                 cap_wb, cap_mr, cap_mw, cap_s, cap_b;
  logic [1:0]           cap_cv;
  logic [REG_IDX_W-1:0] cap_dest;
  logic [ADDR_W-1:0]    cap_pc, cap_br;
  logic                 load_mul_c;

  assign is_mul_c   = (cmd == CMD_MUL);
  assign mul_last_c = (count == CNT_W'(MUL_STEPS - 1));
  assign load_mul_c = (state == MUL_DONE) && can_load_c;
  assign busy       = (state == MUL_RUN);

  // Partial product of the low MUL_BPC multiplier bits
  always_comb begin
    pp_c = '0;
    for (int unsigned i = 0; i < MUL_BPC; i++) begin
      if (mplier[i]) pp_c = pp_c + (mcand << i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      cap_wb   <= 1'b0;
      cap_mr   <= 1'b0;
      cap_mw   <= 1'b0;
      cap_s    <= 1'b0;
      cap_b    <= 1'b0;
      cap_cv   <= '0;
      cap_dest <= '0;
      cap_pc   <= '0;
      cap_br   <= '0;
      cap_rm   <= '0;
    end else if (accept_c && is_mul_c) begin
      mcand    <= val_rn;
      mplier   <= val2;
      acc      <= '0;
      count    <= '0;
      cap_wb   <= wb_en_in;
      cap_mr   <= mem_read_in;
      cap_mw   <= mem_write_in;
      cap_s    <= s_in;
      cap_b    <= b_in;
      cap_cv   <= sr_in[1:0];
      cap_dest <= dest_in;
      cap_pc   <= pc_in;
      cap_br   <= br_addr_c;
      cap_rm   <= val_rm;
    end else if (state == MUL_RUN) begin
      acc    <= acc + pp_c;
      mcand  <= mcand << MUL_BPC;
      mplier <= mplier >> MUL_BPC;
      count  <= count + CNT_W'(1);
    end
  end
`else
  assign is_mul_c   = 1'b0;
  assign mul_last_c = 1'b1;
  assign busy       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept_c && is_mul_c) state_nxt = MUL_RUN;
      MUL_RUN:  if (mul_last_c) state_nxt = MUL_DONE;
      MUL_DONE: if (can_load_c) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // EX/MEM register: flush beats load, load beats drain, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      alu_res        <= '0;
      sr_out         <= '0;
      sr_we          <= 1'b0;
      branch_taken   <= 1'b0;
      branch_address <= '0;
      wb_en_out      <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      dest_out       <= '0;
      val_rm_out     <= '0;
      pc_out         <= '0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      sr_we         <= 1'b0;
      branch_taken  <= 1'b0;
      wb_en_out     <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end else if (load_single_c) begin
      out_valid      <= 1'b1;
      alu_res        <= res_c;
      sr_out         <= sr_c;
      sr_we          <= s_in;
      branch_taken   <= b_in;
      branch_address <= br_addr_c;
      wb_en_out      <= wb_en_in;
      mem_read_out   <= mem_read_in;
      mem_write_out  <= mem_write_in;
      dest_out       <= dest_in;
      val_rm_out     <= val_rm;
      pc_out         <= pc_in;
`ifdef EXE_MUL_EN
    end else if (load_mul_c) begin
      out_valid      <= 1'b1;
      alu_res        <= acc;
      sr_out         <= {acc[DATA_W-1], (acc == '0), cap_cv};
      sr_we          <= cap_s;
      branch_taken   <= cap_b;
      branch_address <= cap_br;
      wb_en_out      <= cap_wb;
      mem_read_out   <= cap_mr;
      mem_write_out  <= cap_mw;
      dest_out       <= cap_dest;
      val_rm_out     <= cap_rm;
      pc_out         <= cap_pc;
`endif
    end else if (out_ready) begin
      out_valid     <= 1'b0;
      sr_we         <= 1'b0;
      branch_taken  <= 1'b0;
      wb_en_out     <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: directed cases plus random traffic against a cycle-level behavioural model.
module tb_exe_stage_mc;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned BPC   = 4;
  localparam int unsigned RW    = 4;
  localparam int unsigned STEPS = DW / BPC;
`ifdef EXE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] cmd, sr_in, sr_out;
  logic wb_en_in, mem_read_in, mem_write_in, s_in, b_in;
  logic [RW-1:0] dest_in, dest_out;
  logic [AW-1:0] pc_in, pc_out, branch_address;
  logic [DW-1:0] val_rn, val2, val_rm, val_rm_out, alu_res;
  logic [23:0] imm24;
  logic sr_we, branch_taken, wb_en_out, mem_read_out, mem_write_out;

  exe_stage_mc #(.DATA_W(DW), .ADDR_W(AW), .MUL_BPC(BPC), .REG_IDX_W(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .s_in(s_in), .b_in(b_in), .dest_in(dest_in), .pc_in(pc_in), .val_rn(val_rn),
    .val2(val2), .val_rm(val_rm), .imm24(imm24), .sr_in(sr_in), .out_valid(out_valid),
    .out_ready(out_ready), .alu_res(alu_res), .sr_out(sr_out), .sr_we(sr_we),
    .branch_taken(branch_taken), .branch_address(branch_address), .wb_en_out(wb_en_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .dest_out(dest_out),
    .val_rm_out(val_rm_out), .pc_out(pc_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res; logic [3:0] sr; logic swe, bt; logic [31:0] ba;
    logic wb, mr, mw; logic [3:0] dest; logic [31:0] rm, pc;
  } out_t;

  typedef struct packed {
    logic valid; logic [3:0] cmd; logic wb, mr, mw, s, b; logic [3:0] dest;
    logic [31:0] pc, rn, v2, rm; logic [23:0] imm; logic [3:0] sr;
  } stim_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_valid;
  out_t m_out, mul_pend;
  int   mul_left;
  bit   mul_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one op, from the instruction-set rules
  function automatic out_t model_op(input stim_t s);
    out_t o;
    longint unsigned ua, ub, u;
    longint sa, sb, sv, off;
    logic [31:0] r;
    bit c, v, known, ci;
    o = '0; r = '0; known = 1'b1; c = s.sr[1]; v = s.sr[0];
    ua = s.rn; ub = s.v2; sa = $signed(s.rn); sb = $signed(s.v2);
    case (s.cmd)
      4'h1: r = s.v2;
      4'h9: r = ~s.v2;
      4'h2, 4'h3: begin
        ci = (s.cmd == 4'h3) ? s.sr[1] : 1'b0;
        u = ua + ub + ci; sv = sa + sb + ci;
        r = u[31:0]; c = u[32]; v = (sv > SMAX) || (sv < SMIN);
      end
      4'h4, 4'h5: begin
        ci = (s.cmd == 4'h5) ? !s.sr[1] : 1'b0;
        r = 32'(ua - ub - ci); c = (ua >= ub + ci);
        sv = sa - sb - ci; v = (sv > SMAX) || (sv < SMIN);
      end
      4'h6: r = s.rn & s.v2;
      4'h7: r = s.rn | s.v2;
      4'h8: r = s.rn ^ s.v2;
      4'hA: if (MUL_EN) r = 32'(ua * ub); else known = 1'b0;
      default: known = 1'b0;
    endcase
    o.res = known ? r : 32'h0;
    o.sr  = known ? {r[31], (r == 32'h0), c, v} : s.sr;
    off   = $signed(s.imm) * 4;
    o.ba  = 32'(longint'(s.pc) + off);
    o.swe = s.s; o.bt = s.b; o.wb = s.wb; o.mr = s.mr; o.mw = s.mw;
    o.dest = s.dest; o.rm = s.rm; o.pc = s.pc;
    return o;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_out = '0; mul_pend = '0; mul_left = 0; mul_done = 1'b0;
  endtask

  // Advance the model across one clock edge
  task automatic model_step(input stim_t s, input bit f, input bit r, input bit acc);
    bit old_done, can_load, is_mul;
    int old_left;
    old_done = mul_done; old_left = mul_left;
    can_load = !m_valid || r;
    is_mul = MUL_EN && (s.cmd == 4'hA);
    if (f) begin
      m_valid = 1'b0; m_out.swe = 1'b0; m_out.bt = 1'b0;
      m_out.wb = 1'b0; m_out.mr = 1'b0; m_out.mw = 1'b0;
      mul_left = 0; mul_done = 1'b0;
    end else begin
      if (acc) begin
        if (is_mul) begin mul_left = STEPS; mul_pend = model_op(s); end
        else begin m_valid = 1'b1; m_out = model_op(s); end
      end else if (old_done && can_load) begin
        m_valid = 1'b1; m_out = mul_pend; mul_done = 1'b0;
      end else if (r) begin
        m_valid = 1'b0; m_out.swe = 1'b0; m_out.bt = 1'b0;
      end
      if (old_left > 0) begin
        mul_left = old_left - 1;
        if (mul_left == 0) mul_done = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, mul_left > 0);
    if (m_valid) begin
      chk("alu_res", alu_res, m_out.res);
      chk("sr_out", sr_out, m_out.sr);
      chk("sr_we", sr_we, m_out.swe);
      chk("branch_taken", branch_taken, m_out.bt);
      chk("branch_address", branch_address, m_out.ba);
      chk("ctrl", {wb_en_out, mem_read_out, mem_write_out}, {m_out.wb, m_out.mr, m_out.mw});
      chk("dest_out", dest_out, m_out.dest);
      chk("val_rm_out", val_rm_out, m_out.rm);
      chk("pc_out", pc_out, m_out.pc);
    end else begin
      chk("sr_we_idle", sr_we, 1'b0);
      chk("branch_taken_idle", branch_taken, 1'b0);
    end
  endtask

  task automatic drive(input stim_t s, input bit f, input bit r);
    in_valid = s.valid; cmd = s.cmd; wb_en_in = s.wb; mem_read_in = s.mr;
    mem_write_in = s.mw; s_in = s.s; b_in = s.b; dest_in = s.dest; pc_in = s.pc;
    val_rn = s.rn; val2 = s.v2; val_rm = s.rm; imm24 = s.imm; sr_in = s.sr;
    flush = f; out_ready = r;
  endtask

  // One cycle: called just after a falling edge, returns just after the next one
  task automatic tick(input stim_t s, input bit f, input bit r);
    bit exp_rdy;
    drive(s, f, r);
    #1;
    exp_rdy = (mul_left == 0) && !mul_done && !f && (!m_valid || r);
    chk("in_ready", in_ready, exp_rdy);
    model_step(s, f, r, s.valid && exp_rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom_range(0, 9) < 7);
    s.cmd = 4'($urandom_range(0, 15));
    s.wb = 1'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom);
    s.s = 1'($urandom); s.b = 1'($urandom); s.dest = 4'($urandom);
    s.pc = $urandom; s.rn = pick(); s.v2 = pick(); s.rm = $urandom;
    s.imm = 24'($urandom); s.sr = 4'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s, s2;
    rst = 1'b0;
    model_reset();
    s = rand_stim(); s.valid = 1'b1;
    drive(s, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_zero", {out_valid, alu_res, sr_out, sr_we, branch_taken, busy}, '0);
    chk("rst_zero2", {branch_address, pc_out}, '0);
    chk("rst_zero3", {wb_en_out, mem_read_out, mem_write_out, dest_out, val_rm_out}, '0);
    @(negedge clk);
    rst = 1'b1;

    // ADD signed overflow
    s = idle_stim(); s.valid = 1'b1; s.cmd = 4'h2; s.rn = 32'h7FFF_FFFF; s.v2 = 32'h1; s.s = 1'b1;
    tick(s, 1'b0, 1'b1);
    chk("add_res", alu_res, 32'h8000_0000);
    chk("add_sr", sr_out, 4'b1001);
    chk("add_swe", sr_we, 1'b1);

    // SUB equal operands
    s.cmd = 4'h4; s.rn = 32'h5; s.v2 = 32'h5;
    tick(s, 1'b0, 1'b1);
    chk("sub_res", alu_res, 32'h0);
    chk("sub_sr", sr_out, 4'b0110);

    // Branch targets, backward and forward
    s = idle_stim(); s.valid = 1'b1; s.cmd = 4'h1; s.b = 1'b1; s.pc = 32'h100; s.imm = 24'hFFFFFE;
    tick(s, 1'b0, 1'b1);
    chk("br_taken", branch_taken, 1'b1);
    chk("br_back", branch_address, 32'hF8);
    s.imm = 24'h3;
    tick(s, 1'b0, 1'b1);
    chk("br_fwd", branch_address, 32'h10C);

    if (MUL_EN) begin
      s = idle_stim(); s.valid = 1'b1; s.cmd = 4'hA; s.rn = 32'h12345; s.v2 = 32'h100;
      s.sr = 4'b0010; s.s = 1'b1;
      tick(s, 1'b0, 1'b1);
      s.valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        chk("mul_busy", busy, 1'b1);
        chk("mul_in_ready", in_ready, 1'b0);
        tick(s, 1'b0, 1'b1);
      end
      chk("mul_not_yet", out_valid, 1'b0);
      tick(s, 1'b0, 1'b1);
      chk("mul_valid", out_valid, 1'b1);
      chk("mul_res", alu_res, 32'h0123_4500);
      chk("mul_sr", sr_out, 4'b0010);
    end

    // Backpressure: hold output, queue the next op
    s = idle_stim(); s.valid = 1'b1; s.cmd = 4'h2; s.rn = 32'h1; s.v2 = 32'h2;
    tick(s, 1'b0, 1'b1);
    chk("bp_first", alu_res, 32'h3);
    s2 = idle_stim(); s2.valid = 1'b1; s2.cmd = 4'h7; s2.rn = 32'hF0; s2.v2 = 32'h0F;
    for (int k = 0; k < 5; k++) begin
      tick(s2, 1'b0, 1'b0);
      chk("bp_hold", alu_res, 32'h3);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    tick(s2, 1'b0, 1'b1);
    chk("bp_next", alu_res, 32'hFF);
    chk("bp_next_valid", out_valid, 1'b1);

    if (MUL_EN) begin
      // Flush in the third multiplier cycle
      tick(idle_stim(), 1'b0, 1'b1);
      s = idle_stim(); s.valid = 1'b1; s.cmd = 4'hA; s.rn = 32'h3; s.v2 = 32'h7; s.s = 1'b1;
      tick(s, 1'b0, 1'b1);
      tick(idle_stim(), 1'b0, 1'b1);
      tick(idle_stim(), 1'b0, 1'b1);
      tick(idle_stim(), 1'b1, 1'b1);
      chk("fl_busy", busy, 1'b0);
      chk("fl_valid", out_valid, 1'b0);
      chk("fl_swe", sr_we, 1'b0);
      flush = 1'b0;
      #1;
      chk("fl_in_ready", in_ready, 1'b1);
      repeat (10) tick(idle_stim(), 1'b0, 1'b1);

      // Async reset in the middle of a multiply
      tick(s, 1'b0, 1'b1);
      tick(idle_stim(), 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      chk("rm_busy", busy, 1'b0);
      chk("rm_valid", out_valid, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (10) tick(idle_stim(), 1'b0, 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick(rand_stim(), ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
